// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the stalling 5-stage pipeline: owns ID/EX valid bits and EX tags,
// resolves taken-branch flush, multi-cycle EX occupancy and load-use stalls, counts stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MC_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             id_is_mc,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             ex_busy,
  output logic             id_vld,
  output logic             ex_vld,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned McW = 4;
  localparam logic [McW-1:0] McInit = McW'(MC_CYCLES - 2);

  typedef enum logic {StRun, StMcWait} state_e;

  state_e           state_q;
  logic             id_vld_q, ex_vld_q, ex_ld_q, ex_mc_q;
  logic [REG_W-1:0] ex_rd_q;
  logic [McW-1:0]   mc_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic run, branch, mc_enter, load_use, advance, rs_hit, rt_hit;

  always_comb begin
    run      = (state_q == StRun);
    rs_hit   = id_uses_rs && (id_rs == ex_rd_q);
    rt_hit   = id_uses_rt && (id_rt == ex_rd_q);
    branch   = run && ex_vld_q && ex_branch_taken;
    mc_enter = run && ex_vld_q && ex_mc_q && !branch;
    load_use = run && !branch && !mc_enter && id_vld_q && ex_vld_q && ex_ld_q &&
               (ex_rd_q != '0) && (rs_hit || rt_hit);
    advance  = run && !branch && !mc_enter && !load_use;
  end

  // Enables are gated by rst_n so nothing moves while reset is held.
  always_comb begin
    pc_en       = rst_n && (branch || advance);
    ifid_en     = rst_n && (branch || advance);
    ifid_flush  = rst_n && branch;
    idex_en     = rst_n && (branch || load_use || advance);
    idex_bubble = rst_n && (branch || load_use);
    ex_busy     = rst_n && (!run || mc_enter);
  end

  assign id_vld    = id_vld_q;
  assign ex_vld    = ex_vld_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      id_vld_q    <= 1'b0;
      ex_vld_q    <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_mc_q     <= 1'b0;
      ex_rd_q     <= '0;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      case (state_q)
        StRun: begin
          if (branch) begin
            id_vld_q <= 1'b0;
            ex_vld_q <= 1'b0;
            ex_ld_q  <= 1'b0;
            ex_mc_q  <= 1'b0;
          end else if (mc_enter) begin
            // The entry cycle is the first of MC_CYCLES occupancy cycles.
            state_q  <= StMcWait;
            mc_cnt_q <= McInit;
          end else if (load_use) begin
            ex_vld_q <= 1'b0;
            ex_ld_q  <= 1'b0;
          end else begin
            id_vld_q <= if_valid;
            ex_vld_q <= id_vld_q;
            ex_rd_q  <= id_rd;
            ex_ld_q  <= id_is_load;
            ex_mc_q  <= id_is_mc;
          end
        end
        StMcWait: begin
          if (mc_cnt_q == '0) begin
            ex_mc_q <= 1'b0;
            state_q <= StRun;
          end else begin
            mc_cnt_q <= mc_cnt_q - 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
